// File: rtl/fetch_queue_stage_pkg.sv
// Shared pipeline types for the fetch/decode boundary.
package fetch_queue_stage_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;
    typedef logic        bool_t;
    typedef logic        clock_t;

    // Canonical no-op (addi x0, x0, 0); shown on the output whenever no entry is valid.
    localparam instr_t NOP = 32'h0000_0013;

    localparam int DEFAULT_FETCH_STRIDE = 4;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        addr_t  pc;
        instr_t instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_stage_if.sv
// Bus bundle between the fetch queue stage, instruction memory, execute (redirect) and decode.
interface fetch_queue_stage_if #(
    parameter int QUEUE_DEPTH = 4
);
    import fetch_queue_stage_pkg::*;

    bool_t                         jump_enable;
    addr_t                         jump_address;
    addr_t                         imem_address;
    instr_t                        imem_instruction;
    bool_t                         out_valid;
    bool_t                         out_ready;
    instr_t                        out_instruction;
    addr_t                         out_pc;
    logic [$clog2(QUEUE_DEPTH):0]  queue_count;

    // Fetch stage side.
    modport master (
        input  jump_enable, jump_address, imem_instruction, out_ready,
        output imem_address, out_valid, out_instruction, out_pc, queue_count
    );

    // Environment side: memory, execute and decode.
    modport slave (
        output jump_enable, jump_address, imem_instruction, out_ready,
        input  imem_address, out_valid, out_instruction, out_pc, queue_count
    );

endinterface

// File: rtl/fetch_queue_stage_instruction_queue.sv
// Synchronous FIFO of fetch entries; flush clears it in one cycle and beats a push.
module instruction_queue
    import fetch_queue_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     mem_reg [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == DEPTH_C);
    assign count = count_reg;

    // A pop on an empty queue is dropped; a push into a full queue only lands when the head leaves.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Head slot read straight out of storage, so the output changes only on a clock edge.
    assign head_data = mem_reg[head_reg];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointer and occupancy registers; flush drops every entry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_push) tail_reg <= tail_reg + PTR_W'(1);
            if (do_pop)  head_reg <= head_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (reset_n && !flush && do_push) begin
            mem_reg[tail_reg] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: PC register feeding instruction memory, with a prefetch queue towards decode.
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter int    QUEUE_DEPTH  = 4,
    parameter addr_t RESET_PC     = 32'h0,
    parameter int    FETCH_STRIDE = DEFAULT_FETCH_STRIDE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fetch_queue_stage_if.master  bus
);

    localparam addr_t STRIDE = addr_t'(FETCH_STRIDE);

    addr_t                        pc_reg;
    fetch_entry_t                 push_data;
    fetch_entry_t                 head_data;
    logic [$clog2(QUEUE_DEPTH):0] q_count;
    logic                         q_empty;
    logic                         q_full;
    logic                         pop;
    logic                         push;

    // Handshake: decode takes the head when present; fetch refills whenever a slot is or becomes free.
    assign pop       = ~q_empty & bus.out_ready;
    assign push      = ~bus.jump_enable & (~q_full | pop);
    assign push_data = '{pc: pc_reg, instruction: bus.imem_instruction};

    instruction_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (bus.jump_enable),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    // PC register: reset beats redirect, redirect beats sequential advance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_reg <= RESET_PC;
        end else if (bus.jump_enable) begin
            pc_reg <= bus.jump_address;
        end else if (push) begin
            pc_reg <= pc_reg + STRIDE;
        end
    end

    // Output side: head entry, masked to NOP / pc 0 when the queue is empty.
    always_comb begin
        bus.imem_address    = pc_reg;
        bus.out_valid       = ~q_empty;
        bus.out_instruction = q_empty ? NOP : head_data.instruction;
        bus.out_pc          = q_empty ? addr_t'(0) : head_data.pc;
        bus.queue_count     = q_count;
    end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage against a queue-based reference model.
module tb_fetch_queue_stage;
    import fetch_queue_stage_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    ent_t        mq[$];
    logic [31:0] mpc;

    fetch_queue_stage_if #(.QUEUE_DEPTH(DEPTH)) bus ();

    fetch_queue_stage #(
        .QUEUE_DEPTH  (DEPTH),
        .RESET_PC     (32'h0),
        .FETCH_STRIDE (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: mem[a] = a + 'h1000.
    assign bus.imem_instruction = bus.imem_address + 32'h1000;

    // Drive one cycle of inputs, advance the reference model at the edge, sample point is #1 later.
    task automatic cycle(input logic rn, input logic je, input logic [31:0] ja, input logic rdy);
        int   sz;
        bit   pop;
        ent_t e;
        reset_n          = rn;
        bus.jump_enable  = je;
        bus.jump_address = ja;
        bus.out_ready    = rdy;
        @(posedge clk);
        if (!rn) begin
            mq.delete();
            mpc = 32'h0;
        end else begin
            sz  = mq.size();
            pop = (sz > 0) && rdy;
            if (pop) e = mq.pop_front();
            if (je) begin
                mq.delete();
                mpc = ja;
            end else if (sz < DEPTH || pop) begin
                mq.push_back('{mpc, mpc + 32'h1000});
                mpc = mpc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", bus.out_valid); end
        total++; if (bus.out_instruction !== NOP) begin bad++; $display("FAIL reset_instr got=%h want=%h", bus.out_instruction, NOP); end
        total++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", bus.out_pc); end
        total++; if (bus.queue_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.queue_count); end
        total++; if (bus.imem_address !== 32'h0) begin bad++; $display("FAIL reset_imem got=%h want=0", bus.imem_address); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1);
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%0h want=1", i, bus.out_valid); end
            total++; if (bus.out_pc !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc[%0d] got=%h want=%h", i, bus.out_pc, 32'(4 * i)); end
            total++; if (bus.out_instruction !== 32'(4 * i + 'h1000)) begin bad++; $display("FAIL stream_instr[%0d] got=%h want=%h", i, bus.out_instruction, 32'(4 * i + 'h1000)); end
            $display("stream: pc=%h instr=%h", bus.out_pc, bus.out_instruction);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        total++; if (bus.queue_count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", bus.queue_count); end
        total++; if (bus.imem_address !== 32'h10) begin bad++; $display("FAIL fill_imem got=%h want=10", bus.imem_address); end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        total++; if (bus.imem_address !== 32'h10) begin bad++; $display("FAIL fill_imem_hold got=%h want=10", bus.imem_address); end
        total++; if (bus.queue_count !== 3'd4) begin bad++; $display("FAIL fill_count_hold got=%0d want=4", bus.queue_count); end
        for (int k = 0; k < 5; k++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * k)) begin
                bad++; $display("FAIL drain_pc[%0d] got=%h valid=%0h want=%h", k, bus.out_pc, bus.out_valid, 32'(4 * k));
            end
            $display("drain: pc=%h instr=%h", bus.out_pc, bus.out_instruction);
            cycle(1'b1, 1'b0, 32'h0, 1'b1);
        end
    endtask

    task automatic test_toggle();
        logic [31:0] prev_pc;
        logic [31:0] prev_ins;
        logic        rdy;
        for (int i = 0; i < 12; i++) begin
            prev_pc  = bus.out_pc;
            prev_ins = bus.out_instruction;
            rdy      = (i % 2 == 0);
            cycle(1'b1, 1'b0, 32'h0, rdy);
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL toggle_valid[%0d] got=%0h want=1", i, bus.out_valid); end
            if (rdy) begin
                total++; if (bus.out_pc !== prev_pc + 32'd4) begin bad++; $display("FAIL toggle_step[%0d] got=%h want=%h", i, bus.out_pc, prev_pc + 32'd4); end
            end else begin
                total++; if (bus.out_pc !== prev_pc || bus.out_instruction !== prev_ins) begin
                    bad++; $display("FAIL toggle_hold[%0d] got=%h/%h want=%h/%h", i, bus.out_pc, bus.out_instruction, prev_pc, prev_ins);
                end
            end
            $display("toggle: ready=%0b pc=%h instr=%h", rdy, bus.out_pc, bus.out_instruction);
        end
    endtask

    task automatic test_jump();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        total++; if (bus.queue_count !== 3'd3) begin bad++; $display("FAIL jump_pre_count got=%0d want=3", bus.queue_count); end
        cycle(1'b1, 1'b1, 32'h200, 1'b1);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL jump_bubble got=%0h want=0", bus.out_valid); end
        total++; if (bus.imem_address !== 32'h200) begin bad++; $display("FAIL jump_imem got=%h want=200", bus.imem_address); end
        total++; if (bus.queue_count !== 3'd0) begin bad++; $display("FAIL jump_count got=%0d want=0", bus.queue_count); end
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 || bus.out_instruction !== 32'h1200) begin
            bad++; $display("FAIL jump_target got=%0h/%h/%h want=1/200/1200", bus.out_valid, bus.out_pc, bus.out_instruction);
        end
        $display("jump: pc=%h instr=%h", bus.out_pc, bus.out_instruction);
    endtask

    task automatic test_back_to_back_jump();
        bit seen;
        cycle(1'b1, 1'b1, 32'h100, 1'b1);
        cycle(1'b1, 1'b1, 32'h300, 1'b1);
        total++; if (bus.imem_address !== 32'h300) begin bad++; $display("FAIL b2b_imem got=%h want=300", bus.imem_address); end
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (bus.out_valid === 1'b1) seen = 1'b1;
            else cycle(1'b1, 1'b0, 32'h0, 1'b0);
        end
        total++; if (!seen || bus.out_pc !== 32'h300) begin
            bad++; $display("FAIL b2b_first got=%h valid=%0b want=300", bus.out_pc, seen);
        end
        $display("b2b: pc=%h instr=%h", bus.out_pc, bus.out_instruction);
    endtask

    task automatic test_reset_over_jump();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'h500, 1'b1);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstjmp_valid got=%0h want=0", bus.out_valid); end
        total++; if (bus.queue_count !== 3'd0) begin bad++; $display("FAIL rstjmp_count got=%0d want=0", bus.queue_count); end
        total++; if (bus.imem_address !== 32'h0) begin bad++; $display("FAIL rstjmp_imem got=%h want=0", bus.imem_address); end
        total++; if (bus.out_pc !== 32'h0 || bus.out_instruction !== NOP) begin
            bad++; $display("FAIL rstjmp_out got=%h/%h want=0/%h", bus.out_pc, bus.out_instruction, NOP);
        end
    endtask

    task automatic test_random();
        logic        rn, je, rdy, ev;
        logic [31:0] ja, epc, eins;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rn  = ($urandom_range(0, 99) != 0);
            je  = ($urandom_range(0, 9) == 0);
            ja  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            rdy = ($urandom_range(0, 2) != 0);
            if (bus.out_valid === 1'b1 && rdy && rn)
                $display("rand: pop pc=%h instr=%h", bus.out_pc, bus.out_instruction);
            cycle(rn, je, ja, rdy);
            ev   = (mq.size() != 0);
            epc  = ev ? mq[0].pc  : 32'h0;
            eins = ev ? mq[0].ins : NOP;
            total++; if (bus.out_valid !== ev || bus.out_pc !== epc || bus.out_instruction !== eins) begin
                bad++; $display("FAIL rand_out[%0d] got=%0h/%h/%h want=%0h/%h/%h", i, bus.out_valid, bus.out_pc, bus.out_instruction, ev, epc, eins);
            end
            total++; if (bus.queue_count !== 3'(mq.size()) || bus.imem_address !== mpc) begin
                bad++; $display("FAIL rand_state[%0d] got=%0d/%h want=%0d/%h", i, bus.queue_count, bus.imem_address, mq.size(), mpc);
            end
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.jump_enable  = 1'b0;
        bus.jump_address = 32'h0;
        bus.out_ready    = 1'b0;
        mpc              = 32'h0;
        test_reset();
        test_stream();
        test_fill();
        test_toggle();
        test_jump();
        test_back_to_back_jump();
        test_reset_over_jump();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
